exception_controller: RTL and testbench

Sequences precise memory-exception handling for the pipelined core. It consumes the 2-bit exception code from the memory-stage exception detector, then runs a fixed sequence: save EPC and cause, flush the pipeline, and fetch the 32-bit handler address as two 16-bit words from the vector table over a request/valid memory port. It finally redirects the PC. It sits between the hazard/exception detection logic, the EPC register file slot and the PC-select mux.

---
 rtl/exception_controller_if.sv | 11 +
 rtl/exception_controller.sv | 141 ++++++++++++++
 tb/tb_exception_controller.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exception_controller_if.sv
// Vector-table read port: the controller issues a word request and the memory
// answers with one data beat qualified by vec_valid.
interface exception_controller_if;
   logic        vec_req;
   logic [31:0] vec_addr;
   logic [15:0] vec_data;
   logic        vec_valid;

   modport master (output vec_req, vec_addr, input vec_data, vec_valid);
   modport slave  (input vec_req, vec_addr, output vec_data, vec_valid);
endinterface

// File: rtl/exception_controller.sv
// Precise memory-exception sequencer: saves EPC/cause, flushes the pipeline,
// fetches the 32-bit handler address as two 16-bit vector words, then redirects.
module exception_controller #(
   parameter logic [31:0] VEC_BASE    = 32'h0000_0002,
   parameter int          TIMEOUT     = 16,
   parameter logic [31:0] FALLBACK_PC = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    i_exc_code,
   input  logic                          i_exc_en,
   input  logic [31:0]                   i_mem_pc,
   output logic                          o_busy,
   output logic                          o_stall,
   output logic                          o_flush,
   output logic [31:0]                   o_epc,
   output logic                          o_epc_we,
   output logic [1:0]                    o_cause,
   output logic                          o_pc_sel,
   output logic [31:0]                   o_pc_target,
   output logic                          o_vec_fault,
   exception_controller_if.master        vec
);

   typedef enum logic [2:0] {IDLE, FLUSH, FETCH_HI, FETCH_LO, REDIRECT} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  cause_reg;
   logic [31:0] epc_reg;
   logic [31:0] target_reg;
   logic [31:0] addr_reg;
   logic [4:0]  cnt_reg;
   logic        fault_reg;

   logic accept;
   logic timeout;

   assign accept  = i_exc_en && (i_exc_code != 2'b00);
   assign timeout = (cnt_reg == 5'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cause_reg  <= 2'b00;
         epc_reg    <= 32'h0;
         target_reg <= 32'h0;
         addr_reg   <= 32'h0;
         cnt_reg    <= 5'd0;
         fault_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  cause_reg <= (i_exc_code == 2'b10) ? 2'b10 : 2'b01;
                  epc_reg   <= i_mem_pc;
               end
            end
            FLUSH: begin
               addr_reg <= (cause_reg == 2'b10) ? VEC_BASE + 32'd2 : VEC_BASE;
               cnt_reg  <= 5'd0;
            end
            FETCH_HI: begin
               // A beat in the final wait cycle still counts; valid beats timeout.
               if (vec.vec_valid) begin
                  target_reg[31:16] <= vec.vec_data;
                  addr_reg          <= addr_reg + 32'd1;
                  cnt_reg           <= 5'd0;
               end else if (timeout) begin
                  target_reg <= FALLBACK_PC;
                  fault_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 5'd1;
               end
            end
            FETCH_LO: begin
               if (vec.vec_valid) begin
                  target_reg[15:0] <= vec.vec_data;
               end else if (timeout) begin
                  target_reg <= FALLBACK_PC;
                  fault_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 5'd1;
               end
            end
            REDIRECT: fault_reg <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next  = state_reg;
      o_busy      = 1'b0;
      o_stall     = 1'b0;
      o_flush     = 1'b0;
      o_epc_we    = 1'b0;
      o_pc_sel    = 1'b0;
      o_vec_fault = 1'b0;
      vec.vec_req = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = FLUSH;
         end
         FLUSH: begin
            o_busy     = 1'b1;
            o_stall    = 1'b1;
            o_flush    = 1'b1;
            o_epc_we   = 1'b1;
            state_next = FETCH_HI;
         end
         FETCH_HI: begin
            o_busy      = 1'b1;
            o_stall     = 1'b1;
            vec.vec_req = 1'b1;
            if (vec.vec_valid)  state_next = FETCH_LO;
            else if (timeout)   state_next = REDIRECT;
         end
         FETCH_LO: begin
            o_busy      = 1'b1;
            o_stall     = 1'b1;
            vec.vec_req = 1'b1;
            if (vec.vec_valid || timeout) state_next = REDIRECT;
         end
         REDIRECT: begin
            o_busy      = 1'b1;
            o_stall     = 1'b1;
            o_pc_sel    = 1'b1;
            o_vec_fault = fault_reg;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign o_epc        = epc_reg;
   assign o_cause      = cause_reg;
   assign o_pc_target  = target_reg;
   assign vec.vec_addr = addr_reg;

endmodule

// File: tb/tb_exception_controller.sv
// Randomised bench for exception_controller against a cycle-count/address
// model of the exception sequence, with a scripted vector-memory responder.
module tb_exception_controller;
   localparam logic [31:0] VEC_BASE    = 32'h0000_0002;
   localparam int          TIMEOUT     = 16;
   localparam logic [31:0] FALLBACK_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  i_exc_code;
   logic        i_exc_en;
   logic [31:0] i_mem_pc;
   logic        o_busy, o_stall, o_flush, o_epc_we, o_pc_sel, o_vec_fault;
   logic [31:0] o_epc, o_pc_target;
   logic [1:0]  o_cause;

   exception_controller_if vif ();

   exception_controller #(
      .VEC_BASE(VEC_BASE), .TIMEOUT(TIMEOUT), .FALLBACK_PC(FALLBACK_PC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_exc_code(i_exc_code), .i_exc_en(i_exc_en),
      .i_mem_pc(i_mem_pc), .o_busy(o_busy), .o_stall(o_stall), .o_flush(o_flush),
      .o_epc(o_epc), .o_epc_we(o_epc_we), .o_cause(o_cause), .o_pc_sel(o_pc_sel),
      .o_pc_target(o_pc_target), .o_vec_fault(o_vec_fault), .vec(vif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // observations of the last run
   int          ob_sel_cyc, ob_flush_cyc, ob_flush_n, ob_we_n, ob_sel_n, ob_fault_n;
   int          ob_stall_n, ob_done_cyc;
   logic [31:0] ob_target, ob_epc, ob_hi_addr, ob_lo_addr;
   logic [1:0]  ob_cause;
   logic        ob_fault, ob_any_out, ob_rst_zero, ob_addr_stable;

   // expected results from the model
   int          ex_sel;
   logic [31:0] ex_target, ex_hi_addr, ex_lo_addr;
   logic [1:0]  ex_cause;
   logic        ex_fault, ex_hi_to;

   // Model: cause mapping, vector slot and latency from wait counts alone.
   task automatic model(input logic [1:0] c, input int hw, input int lw,
                        input logic [15:0] hd, input logic [15:0] ld);
      ex_cause   = (c == 2'b10) ? 2'b10 : 2'b01;
      ex_hi_addr = VEC_BASE + ((ex_cause == 2'b10) ? 32'd2 : 32'd0);
      ex_lo_addr = ex_hi_addr + 32'd1;
      ex_hi_to   = (hw >= TIMEOUT);
      if (ex_hi_to) begin
         ex_sel = 2 + TIMEOUT;          ex_target = FALLBACK_PC; ex_fault = 1'b1;
      end else if (lw >= TIMEOUT) begin
         ex_sel = 3 + hw + TIMEOUT;     ex_target = FALLBACK_PC; ex_fault = 1'b1;
      end else begin
         ex_sel = 4 + hw + lw;          ex_target = {hd, ld};    ex_fault = 1'b0;
      end
   endtask

   // Presents one exception in cycle 0 and plays the vector memory.
   task automatic run_exc(input logic [1:0] c, input logic e, input logic [31:0] p,
                          input int hw, input int lw, input logic [15:0] hd,
                          input logic [15:0] ld, input int nest_cyc,
                          input int rst_cyc, input int limit);
      int phase = 0, waited = 0;
      logic prev_req = 1'b0, prev_valid = 1'b0;
      logic [31:0] prev_addr = 32'h0;
      ob_sel_cyc = -1; ob_flush_cyc = -1; ob_flush_n = 0; ob_we_n = 0; ob_sel_n = 0;
      ob_fault_n = 0; ob_stall_n = 0; ob_done_cyc = -1; ob_target = 32'hx;
      ob_epc = 32'hx; ob_cause = 2'bx; ob_fault = 1'bx; ob_hi_addr = 32'hx;
      ob_lo_addr = 32'hx; ob_any_out = 1'b0; ob_rst_zero = 1'b0; ob_addr_stable = 1'b1;
      @(negedge clk);
      i_exc_code = c; i_exc_en = e; i_mem_pc = p; vif.vec_valid = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         @(negedge clk);
         if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
            ob_rst_zero = !o_busy && !o_stall && !o_flush && !o_epc_we && !o_pc_sel &&
                          !o_vec_fault && !vif.vec_req && o_epc == 32'h0 &&
                          o_cause == 2'b00 && o_pc_target == 32'h0 && vif.vec_addr == 32'h0;
            rst_n = 1'b1; vif.vec_valid = 1'b0; i_exc_code = 2'b00;
            break;
         end
         if (o_flush)  begin ob_flush_n++; ob_flush_cyc = cyc; end
         if (o_epc_we) ob_we_n++;
         if (o_stall)  ob_stall_n++;
         if (o_vec_fault) ob_fault_n++;
         if (o_flush || o_epc_we || vif.vec_req || o_pc_sel || o_busy || o_stall || o_vec_fault)
            ob_any_out = 1'b1;
         if (o_pc_sel) begin
            ob_sel_n++;
            if (ob_sel_cyc < 0) begin
               ob_sel_cyc = cyc; ob_target = o_pc_target; ob_fault = o_vec_fault;
               ob_epc = o_epc; ob_cause = o_cause;
            end
         end
         if (prev_req && vif.vec_req && !prev_valid && vif.vec_addr !== prev_addr)
            ob_addr_stable = 1'b0;
         if (ob_sel_cyc >= 0 && !o_busy) begin
            ob_done_cyc = cyc;
            break;
         end
         prev_req = vif.vec_req; prev_addr = vif.vec_addr;
         i_exc_code = (cyc == nest_cyc) ? 2'b10 : 2'b00;
         vif.vec_valid = 1'b0;
         vif.vec_data  = 16'($urandom);
         if (vif.vec_req && phase < 2) begin
            if (waited == 0) begin
               if (phase == 0) ob_hi_addr = vif.vec_addr;
               else            ob_lo_addr = vif.vec_addr;
            end
            if (waited == ((phase == 0) ? hw : lw)) begin
               vif.vec_valid = 1'b1;
               vif.vec_data  = (phase == 0) ? hd : ld;
               phase++; waited = 0;
            end else begin
               waited++;
            end
         end
         prev_valid = vif.vec_valid;
         if (cyc == rst_cyc) rst_n = 1'b0;
      end
      i_exc_code = 2'b00; vif.vec_valid = 1'b0;
      $display("run code=%b en=%b pc=%h hw=%0d lw=%0d sel_cyc=%0d target=%h fault=%0d",
               c, e, p, hw, lw, ob_sel_cyc, ob_target, ob_fault_n);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_exc_code = 2'b00; i_exc_en = 1'b0; i_mem_pc = 32'h0;
      vif.vec_valid = 1'b0; vif.vec_data = 16'h0;
      repeat (2) @(negedge clk);
      total++; if (o_busy !== 1'b0 || o_stall !== 1'b0) begin bad++;
         $display("FAIL reset_busy got=%b%b want=00", o_busy, o_stall); end
      total++; if (o_epc !== 32'h0 || o_cause !== 2'b00) begin bad++;
         $display("FAIL reset_epc_cause got=%h/%b want=0/00", o_epc, o_cause); end
      total++; if (o_pc_target !== 32'h0 || vif.vec_addr !== 32'h0) begin bad++;
         $display("FAIL reset_target_addr got=%h/%h want=0/0", o_pc_target, vif.vec_addr); end
      total++; if ({o_flush, o_epc_we, o_pc_sel, o_vec_fault, vif.vec_req} !== 5'b0) begin bad++;
         $display("FAIL reset_strobes got=%b want=00000",
                  {o_flush, o_epc_we, o_pc_sel, o_vec_fault, vif.vec_req}); end
      rst_n = 1'b1;
   endtask

   task automatic test_cause01;
      model(2'b01, 0, 0, 16'h0000, 16'h0400);
      run_exc(2'b01, 1'b1, 32'h0000_1234, 0, 0, 16'h0000, 16'h0400, -1, -1, 60);
      total++; if (ob_flush_cyc !== 1 || ob_flush_n !== 1 || ob_we_n !== 1) begin bad++;
         $display("FAIL c01_flush got=cyc%0d n%0d we%0d want=cyc1 n1 we1",
                  ob_flush_cyc, ob_flush_n, ob_we_n); end
      total++; if (ob_epc !== 32'h1234 || ob_cause !== 2'b01) begin bad++;
         $display("FAIL c01_epc_cause got=%h/%b want=00001234/01", ob_epc, ob_cause); end
      total++; if (ob_sel_cyc !== ex_sel || ob_sel_cyc !== 4) begin bad++;
         $display("FAIL c01_sel_cycle got=%0d want=4", ob_sel_cyc); end
      total++; if (ob_target !== 32'h0000_0400 || ob_fault_n !== 0) begin bad++;
         $display("FAIL c01_target got=%h fault=%0d want=00000400 fault=0", ob_target, ob_fault_n); end
      total++; if (ob_hi_addr !== 32'd2 || ob_lo_addr !== 32'd3) begin bad++;
         $display("FAIL c01_addr got=%h/%h want=2/3", ob_hi_addr, ob_lo_addr); end
      total++; if (ob_done_cyc !== 5 || ob_sel_n !== 1) begin bad++;
         $display("FAIL c01_idle got=cyc%0d sel_n%0d want=cyc5 sel_n1", ob_done_cyc, ob_sel_n); end
      total++; if (o_pc_target !== 32'h0000_0400) begin bad++;
         $display("FAIL c01_target_hold got=%h want=00000400", o_pc_target); end
   endtask

   task automatic test_cause10_waits;
      model(2'b10, 3, 3, 16'h0001, 16'h8000);
      run_exc(2'b10, 1'b1, 32'h0000_5678, 3, 3, 16'h0001, 16'h8000, -1, -1, 60);
      total++; if (ob_hi_addr !== ex_hi_addr || ob_lo_addr !== ex_lo_addr) begin bad++;
         $display("FAIL c10_addr got=%h/%h want=%h/%h", ob_hi_addr, ob_lo_addr, ex_hi_addr, ex_lo_addr); end
      total++; if (ob_target !== 32'h0001_8000 || ob_sel_cyc !== 10) begin bad++;
         $display("FAIL c10_sel got=%h@%0d want=00018000@10", ob_target, ob_sel_cyc); end
      total++; if (ob_stall_n !== 10 || !ob_addr_stable) begin bad++;
         $display("FAIL c10_stall got=%0d stable=%b want=10 stable=1", ob_stall_n, ob_addr_stable); end
      total++; if (ob_cause !== 2'b10) begin bad++;
         $display("FAIL c10_cause got=%b want=10", ob_cause); end
   endtask

   task automatic test_code11_disabled;
      run_exc(2'b11, 1'b1, 32'h0000_0abc, 1, 0, 16'h1111, 16'h2222, -1, -1, 60);
      total++; if (ob_cause !== 2'b01 || ob_hi_addr !== 32'd2 || ob_lo_addr !== 32'd3) begin bad++;
         $display("FAIL c11_map got=%b %h/%h want=01 2/3", ob_cause, ob_hi_addr, ob_lo_addr); end
      run_exc(2'b01, 1'b0, 32'h0000_0def, 0, 0, 16'h0, 16'h0, -1, -1, 8);
      total++; if (ob_any_out !== 1'b0 || ob_sel_cyc !== -1) begin bad++;
         $display("FAIL disabled got=any%b sel%0d want=any0 sel-1", ob_any_out, ob_sel_cyc); end
      i_exc_en = 1'b1;
   endtask

   task automatic test_timeout;
      model(2'b01, 1000, 0, 16'h0, 16'h0);
      run_exc(2'b01, 1'b1, 32'h0000_0100, 1000, 0, 16'h0, 16'h0, -1, -1, 80);
      total++; if (ob_sel_cyc !== ex_sel || ob_target !== FALLBACK_PC || ob_fault !== 1'b1) begin bad++;
         $display("FAIL to_hi got=%0d %h f%b want=%0d %h f1", ob_sel_cyc, ob_target, ob_fault, ex_sel, FALLBACK_PC); end
      total++; if (ob_fault_n !== 1) begin bad++;
         $display("FAIL to_fault_pulse got=%0d want=1", ob_fault_n); end
      model(2'b01, TIMEOUT - 1, 1000, 16'h7777, 16'h0);
      run_exc(2'b01, 1'b1, 32'h0000_0104, TIMEOUT - 1, 1000, 16'h7777, 16'h0, -1, -1, 80);
      total++; if (ob_sel_cyc !== 34 || ob_target !== FALLBACK_PC || ob_fault !== 1'b1) begin bad++;
         $display("FAIL to_worst got=%0d %h f%b want=34 %h f1", ob_sel_cyc, ob_target, ob_fault, FALLBACK_PC); end
      model(2'b10, TIMEOUT - 1, TIMEOUT - 1, 16'h1234, 16'h5678);
      run_exc(2'b10, 1'b1, 32'h0000_0108, TIMEOUT - 1, TIMEOUT - 1, 16'h1234, 16'h5678, -1, -1, 80);
      total++; if (ob_sel_cyc !== ex_sel || ob_target !== 32'h1234_5678 || ob_fault_n !== 0) begin bad++;
         $display("FAIL to_edge_valid got=%0d %h f%0d want=%0d 12345678 f0", ob_sel_cyc, ob_target, ob_fault_n, ex_sel); end
   endtask

   task automatic test_nested;
      model(2'b01, 2, 1, 16'hcafe, 16'hbeef);
      run_exc(2'b01, 1'b1, 32'habcd_0000, 2, 1, 16'hcafe, 16'hbeef, 2, -1, 60);
      total++; if (ob_cause !== 2'b01 || ob_epc !== 32'habcd_0000) begin bad++;
         $display("FAIL nest_keep got=%b/%h want=01/abcd0000", ob_cause, ob_epc); end
      total++; if (ob_hi_addr !== ex_hi_addr || ob_lo_addr !== ex_lo_addr || ob_sel_cyc !== ex_sel) begin bad++;
         $display("FAIL nest_seq got=%h/%h@%0d want=%h/%h@%0d", ob_hi_addr, ob_lo_addr, ob_sel_cyc,
                  ex_hi_addr, ex_lo_addr, ex_sel); end
      total++; if (ob_flush_n !== 1 || ob_sel_n !== 1 || o_busy !== 1'b0) begin bad++;
         $display("FAIL nest_once got=f%0d s%0d b%b want=f1 s1 b0", ob_flush_n, ob_sel_n, o_busy); end
   endtask

   task automatic test_reset_mid;
      run_exc(2'b10, 1'b1, 32'h0000_9999, 0, 5, 16'h1, 16'h2, -1, 4, 60);
      total++; if (ob_rst_zero !== 1'b1 || ob_sel_n !== 0) begin bad++;
         $display("FAIL rst_mid got=zero%b sel%0d want=zero1 sel0", ob_rst_zero, ob_sel_n); end
      model(2'b01, 1, 2, 16'h00aa, 16'h00bb);
      run_exc(2'b01, 1'b1, 32'h0000_4444, 1, 2, 16'h00aa, 16'h00bb, -1, -1, 60);
      total++; if (ob_sel_cyc !== ex_sel || ob_target !== ex_target || ob_epc !== 32'h4444) begin bad++;
         $display("FAIL rst_recover got=%0d %h %h want=%0d %h 00004444", ob_sel_cyc, ob_target, ob_epc,
                  ex_sel, ex_target); end
   endtask

   task automatic test_random;
      for (int n = 0; n < 20; n++) begin
         logic [1:0]  c  = 2'($urandom_range(1, 3));
         logic [31:0] p  = $urandom;
         int          hw = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
         int          lw = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
         logic [15:0] hd = 16'($urandom);
         logic [15:0] ld = 16'($urandom);
         model(c, hw, lw, hd, ld);
         run_exc(c, 1'b1, p, hw, lw, hd, ld, -1, -1, 80);
         total++;
         if (ob_sel_cyc !== ex_sel || ob_target !== ex_target || ob_fault_n !== int'(ex_fault) ||
             ob_cause !== ex_cause || ob_epc !== p || ob_hi_addr !== ex_hi_addr ||
             (!ex_hi_to && ob_lo_addr !== ex_lo_addr) || ob_done_cyc !== ex_sel + 1) begin
            bad++;
            $display("FAIL rand%0d got=%0d %h f%0d %b %h %h/%h want=%0d %h f%0d %b %h %h/%h", n,
                     ob_sel_cyc, ob_target, ob_fault_n, ob_cause, ob_epc, ob_hi_addr, ob_lo_addr,
                     ex_sel, ex_target, ex_fault, ex_cause, p, ex_hi_addr, ex_lo_addr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cause01();
      test_cause10_waits();
      test_code11_disabled();
      test_timeout();
      test_nested();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
